// File: rtl/ysyx_ctrl_pkg.sv
// ============================================================================
// Module : ysyx_ctrl_pkg
// Brief  : Shared types and constants for the EXU sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } ctrl_state_e;

    localparam logic [6:0]  OP_IMM      = 7'b0010011;
    localparam logic [6:0]  OP_JAL      = 7'b1101111;
    localparam logic [6:0]  OP_JALR     = 7'b1100111;
    localparam logic [6:0]  OP_AUIPC    = 7'b0010111;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/ysyx_imm_gen.sv
// ============================================================================
// Module : ysyx_imm_gen
// Brief  : Combinational immediate extraction for the supported opcodes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_imm_gen
    import ysyx_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    // rd field never contributes to an immediate
    logic w_unused_rd;
    assign w_unused_rd = ^inst[11:7];

    always_comb begin
        imm = '0;
        case (inst[6:0])
            OP_IMM, OP_JALR: imm = {{20{inst[31]}}, inst[31:20]};
            OP_JAL:          imm = {{11{inst[31]}}, inst[31], inst[19:12],
                                    inst[20], inst[30:21], 1'b0};
            OP_AUIPC:        imm = {inst[31:12], 12'b0};
            default:         imm = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_exec_ctrl.sv
// ============================================================================
// Module : ysyx_exec_ctrl
// Brief  : Multi-cycle fetch/decode/PC sequencer for the EXU datapath.
//          Define YSYX_CTRL_PERF_EN to add cycle/instret counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_exec_ctrl
    import ysyx_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_req_addr,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] imm,
    output logic        alu_a_sel,
    output logic        rf_wr_sel,
    output logic        rf_wr_en,
    output logic        is_ebreak,
    input  logic [31:0] jump_addr,
    output logic        halted,
    output logic        illegal
`ifdef YSYX_CTRL_PERF_EN
    ,
    output logic [63:0] perf_cycle,
    output logic [63:0] perf_instret
`endif
);

    ctrl_state_e r_state;
    ctrl_state_e w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_ebreak;
    logic        r_illegal;

    logic w_is_addi, w_is_jalr, w_is_jal, w_is_auipc, w_is_ebreak, w_supported;
    logic w_in_exec;

    assign w_is_addi   = (r_inst[6:0] == OP_IMM)  && (r_inst[14:12] == 3'b000);
    assign w_is_jalr   = (r_inst[6:0] == OP_JALR) && (r_inst[14:12] == 3'b000);
    assign w_is_jal    = (r_inst[6:0] == OP_JAL);
    assign w_is_auipc  = (r_inst[6:0] == OP_AUIPC);
    assign w_is_ebreak = (r_inst == INST_EBREAK);
    assign w_supported = w_is_addi | w_is_jalr | w_is_jal | w_is_auipc;
    assign w_in_exec   = (r_state == S_EXEC);

    ysyx_imm_gen u_imm_gen (
        .inst (r_inst),
        .imm  (imm)
    );

    // Mux selects follow the latched word at all times; only the write enable is gated by EXEC
    assign alu_a_sel     = ~(w_is_jal | w_is_auipc);
    assign rf_wr_sel     = w_is_jal | w_is_jalr;
    assign rf_wr_en      = w_in_exec & w_supported;
    assign is_ebreak     = r_ebreak | (w_in_exec & w_is_ebreak);
    assign illegal       = r_illegal;
    assign halted        = (r_state == S_HALT);
    assign ifu_req_valid = (r_state == S_FETCH);
    assign ifu_req_addr  = r_pc;
    assign pc            = r_pc;
    assign inst          = r_inst;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: if (ifu_req_ready) w_state_nxt = S_WAIT;
            S_WAIT:  if (ifu_rsp_valid) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = w_supported ? S_FETCH : S_HALT;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_inst    <= INST_NOP;
            r_ebreak  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_WAIT) && ifu_rsp_valid)
                r_inst <= ifu_rsp_inst;
            if (w_in_exec) begin
                if (w_is_jal || w_is_jalr)
                    r_pc <= jump_addr;
                else if (w_is_addi || w_is_auipc)
                    r_pc <= r_pc + 32'd4;
                if (w_is_ebreak)
                    r_ebreak <= 1'b1;
                else if (!w_supported)
                    r_illegal <= 1'b1;
            end
        end
    end

`ifdef YSYX_CTRL_PERF_EN
    logic [63:0] r_perf_cycle;
    logic [63:0] r_perf_instret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cycle   <= 64'd0;
            r_perf_instret <= 64'd0;
        end else begin
            if (r_state != S_HALT)
                r_perf_cycle <= r_perf_cycle + 64'd1;
            if (w_in_exec)
                r_perf_instret <= r_perf_instret + 64'd1;
        end
    end

    assign perf_cycle   = r_perf_cycle;
    assign perf_instret = r_perf_instret;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_exec_ctrl.sv
// ============================================================================
// Module : tb_ysyx_exec_ctrl
// Brief  : Directed self-checking bench for ysyx_exec_ctrl with an
//          instruction-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_exec_ctrl;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_req_addr, ifu_rsp_inst, inst, pc, imm, jump_addr;
    logic        alu_a_sel, rf_wr_sel, rf_wr_en, is_ebreak, halted, illegal;
`ifdef YSYX_CTRL_PERF_EN
    logic [63:0] perf_cycle, perf_instret;
    logic [63:0] m_cycle, m_instret;
`endif

    always #5 clk = ~clk;

    ysyx_exec_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_inst  (ifu_rsp_inst),
        .inst          (inst),
        .pc            (pc),
        .imm           (imm),
        .alu_a_sel     (alu_a_sel),
        .rf_wr_sel     (rf_wr_sel),
        .rf_wr_en      (rf_wr_en),
        .is_ebreak     (is_ebreak),
        .jump_addr     (jump_addr),
        .halted        (halted),
        .illegal       (illegal)
`ifdef YSYX_CTRL_PERF_EN
        ,
        .perf_cycle    (perf_cycle),
        .perf_instret  (perf_instret)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    // Architectural model: what the core has latched, and what phase it is in
    logic [31:0] m_pc, m_inst;
    bit          m_req, m_exec, m_halted, m_ebreak, m_illegal;

    typedef struct packed {
        logic [31:0] imm;
        logic        a_sel;
        logic        wr_sel;
        logic        wr;
        logic        jump;
    } dec_t;

    function automatic dec_t model_dec(input logic [31:0] w);
        dec_t d;
        logic [20:0] jv;
        d = '{imm: 32'd0, a_sel: 1'b1, wr_sel: 1'b0, wr: 1'b0, jump: 1'b0};
        jv = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        case (w[6:0])
            7'b0010011: begin
                d.imm = 32'(int'(w[31:20]) - (w[31] ? 4096 : 0));
                d.wr  = (w[14:12] == 3'd0);
            end
            7'b1100111: begin
                d.imm    = 32'(int'(w[31:20]) - (w[31] ? 4096 : 0));
                d.wr     = (w[14:12] == 3'd0);
                d.wr_sel = d.wr;
                d.jump   = d.wr;
            end
            7'b1101111: begin
                d.imm = 32'(int'(jv) - (w[31] ? 2097152 : 0));
                d.a_sel = 1'b0; d.wr_sel = 1'b1; d.wr = 1'b1; d.jump = 1'b1;
            end
            7'b0010111: begin
                d.imm = w & 32'hFFFF_F000;
                d.a_sel = 1'b0; d.wr = 1'b1;
            end
            default: d.imm = 32'd0;
        endcase
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        dec_t d;
        d = model_dec(m_inst);
        chk("pc",            pc,            m_pc);
        chk("inst",          inst,          m_inst);
        chk("ifu_req_valid", ifu_req_valid, m_req);
        if (m_req) chk("ifu_req_addr", ifu_req_addr, m_pc);
        chk("imm",           imm,           d.imm);
        chk("alu_a_sel",     alu_a_sel,     d.a_sel);
        chk("rf_wr_sel",     rf_wr_sel,     d.wr_sel);
        chk("rf_wr_en",      rf_wr_en,      m_exec && d.wr);
        chk("is_ebreak",     is_ebreak,     m_ebreak || (m_exec && m_inst == EBREAK));
        chk("halted",        halted,        m_halted);
        chk("illegal",       illegal,       m_illegal);
`ifdef YSYX_CTRL_PERF_EN
        chk("perf_cycle",    perf_cycle,    m_cycle);
        chk("perf_instret",  perf_instret,  m_instret);
`endif
    end

    task automatic model_reset();
        m_pc = 32'h8000_0000; m_inst = 32'h0000_0013;
        m_req = 0; m_exec = 0; m_halted = 0; m_ebreak = 0; m_illegal = 0;
`ifdef YSYX_CTRL_PERF_EN
        m_cycle = 64'd0; m_instret = 64'd0;
`endif
    endtask

    task automatic tick();
`ifdef YSYX_CTRL_PERF_EN
        bit cnt_c, cnt_i;
        cnt_c = rst_n && !m_halted;
        cnt_i = rst_n && m_exec;
`endif
        @(posedge clk); #1;
`ifdef YSYX_CTRL_PERF_EN
        if (cnt_c) m_cycle++;
        if (cnt_i) m_instret++;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_inst(input logic [31:0] w, input logic [31:0] jaddr,
                            input int rdy_dly, input int rsp_dly, input bit junk,
                            input logic [31:0] lit_imm);
        dec_t d;
        m_req = 1;
        for (int k = 0; k <= rdy_dly; k++) begin
            ifu_req_ready = (k == rdy_dly);
            ifu_rsp_valid = junk && (k != rdy_dly);
            ifu_rsp_inst  = 32'hDEAD_BEEF;
            tick();
        end
        m_req = 0;
        ifu_req_ready = 1'b0;
        for (int k = 0; k <= rsp_dly; k++) begin
            ifu_rsp_valid = (k == rsp_dly);
            ifu_rsp_inst  = (k == rsp_dly) ? w : 32'hDEAD_BEEF;
            tick();
        end
        m_inst = w;
        m_exec = 1;
        jump_addr     = jaddr;
        ifu_rsp_valid = junk;
        ifu_rsp_inst  = 32'hDEAD_BEEF;
        chk("exec_imm_literal", imm, lit_imm);
        tick();
        m_exec = 0;
        ifu_rsp_valid = 1'b0;
        d = model_dec(w);
        if (d.wr) begin
            m_pc = d.jump ? jaddr : m_pc + 32'd4;
        end else begin
            m_halted = 1;
            if (w == EBREAK) m_ebreak = 1;
            else             m_illegal = 1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
        ifu_rsp_inst = 32'd0; jump_addr = 32'd0;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        run_inst(32'h0050_0093, 32'h0, 0, 0, 0, 32'd5);              // addi x1,x0,5
        chk("pc_after_addi", pc, 32'h8000_0004);
        run_inst(32'h0080_00EF, 32'h8000_0008, 0, 0, 0, 32'd8);      // jal x1,+8
        chk("pc_after_jal", pc, 32'h8000_0008);
        run_inst(32'h1234_5097, 32'h0, 3, 2, 1, 32'h1234_5000);      // auipc, stalled
        chk("pc_after_auipc", pc, 32'h8000_000C);
        run_inst(32'hFFC0_8067, 32'hFFFF_FFFC, 1, 0, 0, 32'hFFFF_FFFC); // jalr x0,-4(x1)
        run_inst(32'hFFF1_0113, 32'h0, 0, 1, 0, 32'hFFFF_FFFF);      // addi, pc wraps
        chk("pc_wrap", pc, 32'h0000_0000);
        run_inst(EBREAK, 32'h1234_0000, 0, 0, 0, 32'd0);
        for (int k = 0; k < 20; k++) begin
            ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0050_0093;
            tick();
        end
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
        chk("halt_no_req", ifu_req_valid, 1'b0);
        chk("halt_ebreak", is_ebreak, 1'b1);

        // abort with a fetch outstanding
        rst_n = 1'b1;
        do_reset();
        m_req = 1; ifu_req_ready = 1'b1; tick();
        m_req = 0; ifu_req_ready = 1'b0; tick();
        do_reset();

        run_inst(32'h0000_0000, 32'h1234_5678, 0, 0, 0, 32'd0);
        tick(); tick();
        chk("illegal_flag", illegal, 1'b1);
        chk("illegal_pc", pc, 32'h8000_0000);
        chk("illegal_halted", halted, 1'b1);

        do_reset();
        run_inst(32'h0050_0093, 32'h0, 0, 0, 0, 32'd5);
        run_inst(EBREAK, 32'h0, 0, 0, 0, 32'd0);
        tick();
`ifdef YSYX_CTRL_PERF_EN
        chk("perf_instret_literal", perf_instret, 64'd2);
`endif
        chk("final_halted", halted, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_exec_ctrl.md
# ysyx_exec_ctrl

Multi-cycle sequencer for the single-cycle EXU datapath (ALU + register file). It owns the PC, fetches instructions over a valid/ready request and valid response interface, and latches the instruction word. It decodes the supported subset into the EXU control signals (`alu_a_sel`, `rf_wr_sel`, `rf_wr_en`, `is_ebreak`, `imm`) and updates the PC from the EXU's `jump_addr`. It sits between the instruction memory/IFU and `ysyx_EXU`, and halts the core on `ebreak` or on an illegal instruction.

## Interface
Parameters:
- `RESET_PC`, default 32'h8000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `ifu_req_valid`  out  1  fetch request valid.
- `ifu_req_ready`  in  1  IFU accepts request.
- `ifu_req_addr`  out  32  fetch address, equal to `pc`.
- `ifu_rsp_valid`  in  1  instruction word valid.
- `ifu_rsp_inst`  in  32  instruction word.
- `inst`  out  32  latched instruction, to the EXU.
- `pc`  out  32  current PC, to the EXU.
- `imm`  out  32  decoded immediate, to the EXU.
- `alu_a_sel`  out  1  1 selects rs1, 0 selects pc.
- `rf_wr_sel`  out  1  1 selects pc+4, 0 selects ALU result.
- `rf_wr_en`  out  1  register-file write enable, single-cycle pulse.
- `is_ebreak`  out  1  ebreak indication.
- `jump_addr`  in  32  jump target computed by the EXU.
- `halted`  out  1  core stopped.
- `illegal`  out  1  sticky illegal-instruction flag.

## Operation
- States are IDLE, FETCH, WAIT, EXEC and HALT. The reset state is IDLE.
- IDLE to FETCH is unconditional after one cycle.
- FETCH:
  - `ifu_req_valid`=1 and `ifu_req_addr`=`pc`.
  - On `ifu_req_valid && ifu_req_ready`, go to WAIT.
  - Address is held stable while ready is low.
- WAIT: on `ifu_rsp_valid`, latch `ifu_rsp_inst` into `inst` and go to EXEC. `ifu_rsp_valid` is ignored in every other state.
- EXEC (exactly one cycle): decode `inst`.
  - `addi` (opcode 0010011, funct3 000): `alu_a_sel`=1, `rf_wr_sel`=0, I-immediate, `pc`<=`pc`+4.
  - `jalr` (opcode 1100111, funct3 000): `alu_a_sel`=1, `rf_wr_sel`=1, I-immediate, `pc`<=`jump_addr`.
  - `jal` (opcode 1101111): `alu_a_sel`=0, `rf_wr_sel`=1, J-immediate, `pc`<=`jump_addr`.
  - `auipc` (opcode 0010111): `alu_a_sel`=0, `rf_wr_sel`=0, U-immediate, `pc`<=`pc`+4.
  - For all four: `rf_wr_en`=1 during EXEC, then go to FETCH.
  - `ebreak` (32'h0010_0073): `rf_wr_en`=0, `is_ebreak`<=1, go to HALT, `pc` unchanged.
  - Anything else: `rf_wr_en`=0, `illegal`<=1, go to HALT, `pc` unchanged.
- Immediates:
  - I-type is sign-extended `inst[31:20]`.
  - J-type is sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
  - U-type is {inst[31:12],12'b0}.
  - `imm` is combinational from `inst`.
  - Unsupported opcodes give `imm`=0.
- HALT: terminal state, exited only by reset. `halted`=1, no requests are issued, and `rf_wr_en`=0.
- `is_ebreak` and `illegal` stay set until reset. `is_ebreak` is a level signal, so the EXU sees exactly one rising edge.
- Writes to rd=x0 are dropped by the register file. The controller does not special-case them.
- PC arithmetic is modulo 2^32 and wrap-around is silent. Misaligned `jump_addr` is not checked.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `inst`=32'h0000_0013 (nop).
  - `ifu_req_valid`=0, `rf_wr_en`=0, `is_ebreak`=0, `illegal`=0, `halted`=0.
  - `alu_a_sel`=1, `rf_wr_sel`=0, `imm`=0.
- Minimum 3 cycles per instruction: FETCH 1, WAIT 1, EXEC 1. Each cycle of `ifu_req_ready`=0 or `ifu_rsp_valid`=0 adds one cycle.
- A response must arrive no earlier than the cycle after request acceptance.
- `pc` and `inst` change only on the clock edge ending EXEC (for `pc`) or WAIT (for `inst`). EXU inputs are therefore stable throughout EXEC.
- Reset asserted mid-operation aborts immediately. Any outstanding fetch is forgotten, and the IFU must be reset by the same `rst_n`.

## Configuration
- Macro `YSYX_CTRL_PERF_EN`.
- Defined: adds outputs `perf_cycle` (64-bit) and `perf_instret` (64-bit), both reset to 0.
  - `perf_cycle` increments every cycle not in HALT.
  - `perf_instret` increments on each EXEC cycle, including ebreak and illegal instructions.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

## Structure
- Package `ysyx_ctrl_pkg` holds:
  - the state enum;
  - opcode constants `OP_IMM`, `OP_JAL`, `OP_JALR`, `OP_AUIPC`;
  - `INST_EBREAK` and `INST_NOP`.
- Sub-module `ysyx_imm_gen`: combinational, takes `inst`, produces `imm`.

## Test plan
- Reset: hold `rst_n`=0, then release.
  - During reset: `pc`=0x8000_0000, `ifu_req_valid`=0, `inst`=0x0000_0013.
  - One IDLE cycle, then `ifu_req_valid`=1 with address 0x8000_0000.
- `addi x1,x0,5` (0x0050_0093), ready=1, response the next cycle:
  - EXEC shows `imm`=5, `alu_a_sel`=1, `rf_wr_sel`=0, and a 1-cycle `rf_wr_en`.
  - Next request addr 0x8000_0004, 3 cycles after the first.
- `jal x1,+8` (0x0080_00EF) with `jump_addr`=0x8000_0008:
  - `imm`=8, `alu_a_sel`=0, `rf_wr_sel`=1, `rf_wr_en`=1.
  - Next fetch addr 0x8000_0008.
- Backpressure: `ifu_req_ready`=0 for 3 cycles, then 1.
  - `ifu_req_valid` stays 1 and the address is stable for 4 cycles.
  - No `rf_wr_en` occurs during the stall.
- `ebreak` (0x0010_0073): `is_ebreak` rises in EXEC, `rf_wr_en`=0, `halted`=1 the next cycle, and no further requests for 20 cycles.
- Illegal 0x0000_0000: `illegal`=1, `halted`=1, `pc` unchanged.
- With `YSYX_CTRL_PERF_EN`: after addi + ebreak, `perf_instret`=2.
